// File: rtl/pdm_cic_decimator_dual_pkg.sv
// Shared constants for the dual-channel PDM CIC decimator: filter order,
// PCM width, accumulator width derivation and output saturation limits.
package pdm_cic_decimator_dual_pkg;

    localparam int CIC_ORDER = 4;
    localparam int PCM_W     = 16;
    localparam int PCM_MAX   = 32767;
    localparam int PCM_MIN   = -32768;

    // Number of decimation ticks swallowed while the comb delays fill.
    localparam logic [2:0] WARM_TICKS = 3'd4;

    // A 2-bit signed input grows by log2(R) bits per integrator stage.
    function automatic int acc_width(input int decim);
        return 2 + CIC_ORDER * $clog2(decim);
    endfunction

endpackage

// File: rtl/pdm_cic_decimator_dual_cic_channel.sv
// One CIC channel: four integrators at input rate, four combs at tick rate,
// then arithmetic shift and saturation into a registered PCM sample.
module cic_channel
    import pdm_cic_decimator_dual_pkg::*;
#(
    parameter int ACC_W = 26
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    sdr_data,
    input  logic                    tick,
    input  logic                    load,
    output logic signed [PCM_W-1:0] pcm
);

    localparam int SHIFT = ACC_W - (PCM_W + 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(PCM_MAX);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(PCM_MIN);

    logic signed [ACC_W-1:0] integ_q   [CIC_ORDER];
    logic signed [ACC_W-1:0] integ_d   [CIC_ORDER];
    logic signed [ACC_W-1:0] comb_dly_q[CIC_ORDER];
    logic signed [ACC_W-1:0] comb_y    [CIC_ORDER+1];
    logic signed [ACC_W-1:0] sample;
    logic signed [ACC_W-1:0] shifted;
    logic signed [PCM_W-1:0] pcm_sat;

    // NOTE: every variable driven here gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        sample  = sdr_data ? ACC_W'(1) : '1;
        integ_d = integ_q;
        comb_y  = '{default: '0};
        pcm_sat = '0;

        // Chain through post-update values so the comb sees this cycle's sample.
        integ_d[0] = integ_q[0] + sample;
        for (int i = 1; i < CIC_ORDER; i++) begin
            integ_d[i] = integ_q[i] + integ_d[i-1];
        end

        comb_y[0] = integ_d[CIC_ORDER-1];
        for (int i = 0; i < CIC_ORDER; i++) begin
            comb_y[i+1] = comb_y[i] - comb_dly_q[i];
        end

        shifted = comb_y[CIC_ORDER] >>> SHIFT;
        if (shifted > SAT_HI) begin
            pcm_sat = PCM_W'(PCM_MAX);
        end else if (shifted < SAT_LO) begin
            pcm_sat = PCM_W'(PCM_MIN);
        end else begin
            pcm_sat = shifted[PCM_W-1:0];
        end
    end

    // NOTE: state registers use non-blocking assignments; the filter arrays are a handful of flops, so all are cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            integ_q    <= '{default: '0};
            comb_dly_q <= '{default: '0};
            pcm        <= '0;
        end else begin
            if (in_valid) begin
                integ_q <= integ_d;
            end
            if (tick) begin
                for (int i = 0; i < CIC_ORDER; i++) begin
                    comb_dly_q[i] <= comb_y[i];
                end
            end
            if (load) begin
                pcm <= pcm_sat;
            end
        end
    end

endmodule

// File: rtl/pdm_cic_decimator_dual.sv
// Dual-microphone PDM to PCM decimator: two CIC channels sharing one
// decimation counter, one warm-up counter and one output strobe.
module pdm_cic_decimator_dual
    import pdm_cic_decimator_dual_pkg::*;
#(
    parameter int DECIM = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    sdr_data_0,
    input  logic                    sdr_data_1,
    output logic signed [PCM_W-1:0] pcm_0,
    output logic signed [PCM_W-1:0] pcm_1,
    output logic                    pcm_valid
);

    localparam int ACC_W = acc_width(DECIM);
    localparam int CNT_W = $clog2(DECIM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    logic [CNT_W-1:0] dec_cnt_q;
    logic [2:0]       warm_q;
    logic             tick;
    logic             warm_done;
    logic             load;

    assign tick      = in_valid && (dec_cnt_q == CNT_LAST);
    assign warm_done = (warm_q == WARM_TICKS);
    assign load      = tick && warm_done;

    // DECIM is a power of two, so the counter wraps on its own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_cnt_q <= '0;
            warm_q    <= '0;
            pcm_valid <= 1'b0;
        end else begin
            pcm_valid <= load;
            if (in_valid) begin
                dec_cnt_q <= dec_cnt_q + CNT_W'(1);
            end
            if (tick && !warm_done) begin
                warm_q <= warm_q + 3'd1;
            end
        end
    end

    cic_channel #(.ACC_W(ACC_W)) u_ch0 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .sdr_data (sdr_data_0),
        .tick     (tick),
        .load     (load),
        .pcm      (pcm_0)
    );

    cic_channel #(.ACC_W(ACC_W)) u_ch1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .sdr_data (sdr_data_1),
        .tick     (tick),
        .load     (load),
        .pcm      (pcm_1)
    );

endmodule

// File: tb/tb_pdm_cic_decimator_dual.sv
// Bench for pdm_cic_decimator_dual: directed and random PDM streams compared
// against an FIR-convolution model of the 4th-order CIC.
module tb_pdm_cic_decimator_dual;

    localparam int R      = 64;
    localparam int SHIFT  = 9;
    localparam int NTAPS  = 4 * R - 3;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               sdr_data_0;
    logic               sdr_data_1;
    logic signed [15:0] pcm_0;
    logic signed [15:0] pcm_1;
    logic               pcm_valid;

    int errors;
    int checks;

    // Model state: accepted samples since reset (+1/-1), tick count, expected outputs.
    int  hist0[$];
    int  hist1[$];
    int  taps[$];
    int  n_acc;
    int  n_ticks;
    int  exp_valid;
    int  exp0;
    int  exp1;
    bit  seen_first;

    pdm_cic_decimator_dual #(.DECIM(R)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .sdr_data_0 (sdr_data_0),
        .sdr_data_1 (sdr_data_1),
        .pcm_0      (pcm_0),
        .pcm_1      (pcm_1),
        .pcm_valid  (pcm_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // CIC impulse response is the R-point boxcar convolved with itself four times.
    task automatic build_taps();
        int nxt[$];
        taps = {};
        for (int i = 0; i < R; i++) taps.push_back(1);
        for (int s = 1; s < 4; s++) begin
            nxt = {};
            for (int i = 0; i < taps.size() + R - 1; i++) nxt.push_back(0);
            for (int i = 0; i < taps.size(); i++)
                for (int j = 0; j < R; j++) nxt[i+j] += taps[i];
            taps = nxt;
        end
    endtask

    function automatic int fir_pcm(input int ch);
        longint acc = 0;
        int n = n_acc;
        for (int k = 0; k < NTAPS && k < n; k++) begin
            acc += longint'(taps[k]) * longint'(ch == 0 ? hist0[n-1-k] : hist1[n-1-k]);
        end
        acc = acc >>> SHIFT;
        if (acc > 32767)  return 32767;
        if (acc < -32768) return -32768;
        return int'(acc);
    endfunction

    task automatic model_clear();
        hist0 = {};
        hist1 = {};
        n_acc = 0;
        n_ticks = 0;
        exp_valid = 0;
        exp0 = 0;
        exp1 = 0;
        seen_first = 0;
    endtask

    // One clock: drive, advance model, then compare just after the edge.
    task automatic step(input logic v, input logic b0, input logic b1);
        in_valid   = v;
        sdr_data_0 = b0;
        sdr_data_1 = b1;
        @(posedge clk);
        #1;
        exp_valid = 0;
        if (v) begin
            hist0.push_back(b0 ? 1 : -1);
            hist1.push_back(b1 ? 1 : -1);
            n_acc++;
            if (n_acc % R == 0) begin
                n_ticks++;
                if (n_ticks > 4) begin
                    exp_valid = 1;
                    exp0 = fir_pcm(0);
                    exp1 = fir_pcm(1);
                end
            end
        end
        check("pcm_valid", pcm_valid, exp_valid);
        check("pcm_0", pcm_0, exp0);
        check("pcm_1", pcm_1, exp1);
        if (pcm_valid === 1'b1 && !seen_first) begin
            seen_first = 1;
            check("first_strobe_inputs", n_acc, 5 * R);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #2;
        check("rst_pcm_valid", pcm_valid, 0);
        check("rst_pcm_0", pcm_0, 0);
        check("rst_pcm_1", pcm_1, 0);
        model_clear();
        for (int i = 0; i < 3; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            sdr_data_0 = 1'($urandom_range(0, 1));
            sdr_data_1 = 1'($urandom_range(0, 1));
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic run_until_strobe(input logic b0, input logic b1);
        int budget = 2000;
        while (!(pcm_valid === 1'b1) && budget > 0) begin
            step(1'b1, b0, b1);
            budget--;
        end
        if (budget == 0) check("wait_strobe_timeout", 0, 1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        in_valid = 1'b0;
        sdr_data_0 = 1'b0;
        sdr_data_1 = 1'b0;
        build_taps();
        model_clear();
        #3;
        apply_reset();

        // Both channels at full-scale positive.
        for (int i = 0; i < 7 * R; i++) step(1'b1, 1'b1, 1'b1);

        // Opposite full-scale on the two channels.
        apply_reset();
        for (int i = 0; i < 7 * R; i++) step(1'b1, 1'b1, 1'b0);

        // Alternating bits: zero mean.
        apply_reset();
        for (int i = 0; i < 7 * R; i++) step(1'b1, 1'(i % 2 == 0), 1'(i % 2 == 0));

        // in_valid every other clock halves the output rate.
        apply_reset();
        for (int i = 0; i < 14 * R; i++) step(1'(i % 2 == 0), 1'b1, 1'b1);

        // Reset 100 clocks after the first strobe, then a fresh warm-up.
        apply_reset();
        run_until_strobe(1'b1, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0);
        apply_reset();
        for (int i = 0; i < 6 * R; i++) step(1'b1, 1'b0, 1'b1);

        // Long in_valid=0 hold mid-frame; the phase resumes from the held count.
        apply_reset();
        for (int i = 0; i < 6 * R + 17; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < 500; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 3 * R; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);

        // Random bits with random gaps, with a bias so the outputs swing.
        apply_reset();
        for (int i = 0; i < 16 * R; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 9) < ((i / (2 * R)) % 10)),
                 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
